// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler slice.
// Provides the 3-bit opcode map, the scheduler FSM state type and a helper
// that classifies opcodes as single- or multi-cycle.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_DIV   = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } sched_state_e;

    // Multiplier and divider need a start pulse and a done handshake.
    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request, response and ALU-side signals of the scheduler.
//   req_*  : request channel (valid/ready), requester -> scheduler
//   rsp_*  : response channel (valid/ready), scheduler -> consumer
//   alu_*  : held opcode/operands, start pulse, unit result and done
// Modports: master = requester/consumer/ALU environment, slave = scheduler.
interface alu_scheduler_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_opcode;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_error;

    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_start;
    logic [WIDTH-1:0] alu_result;
    logic             alu_done;

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready, alu_result, alu_done,
        input  req_ready, rsp_valid, rsp_result, rsp_error,
        input  alu_opcode, alu_a, alu_b, alu_start
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready, alu_result, alu_done,
        output req_ready, rsp_valid, rsp_result, rsp_error,
        output alu_opcode, alu_a, alu_b, alu_start
    );
endinterface

// File: rtl/alu_timeout_counter.sv
// Bounded wait counter for multi-cycle ALU operations.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : force the count to zero (takes priority over enable)
//   enable     : advance the count by one this cycle
//   expired    : count has reached TIMEOUT-1
// The count saturates at TIMEOUT-1, so it never wraps.
module alu_timeout_counter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_scheduler.sv
// Sequencing controller in front of the ALU datapath.
// Accepts one request at a time, holds opcode/operands towards the ALU,
// pulses alu_start for multi-cycle units and waits for alu_done under a
// timeout, then returns the result over the response channel. Divide by
// zero is answered directly (all-ones result, error set) without a start.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : request/response/ALU signals (slave side)
//   busy       : high whenever the FSM is not idle
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_scheduler_if.slave bus,
    output logic           busy
);
    sched_state_e     state_q, state_d;
    logic [2:0]       alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_error_q, rsp_error_d;
    logic             cnt_clear;
    logic             cnt_expired;

    alu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (state_q == StWait),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d      = state_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        cnt_clear    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    alu_opcode_d = bus.req_opcode;
                    alu_a_d      = bus.req_a;
                    alu_b_d      = bus.req_b;
                    if ((bus.req_opcode == OP_DIV) && (bus.req_b == '0)) begin
                        rsp_result_d = '1;
                        rsp_error_d  = 1'b1;
                        state_d      = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (is_multicycle(alu_opcode_q)) begin
                    cnt_clear = 1'b1;
                    state_d   = StWait;
                end else begin
                    rsp_result_d = bus.alu_result;
                    rsp_error_d  = 1'b0;
                    state_d      = StResp;
                end
            end
            StWait: begin
                // Done has priority over a coincident timeout.
                if (bus.alu_done) begin
                    rsp_result_d = bus.alu_result;
                    rsp_error_d  = 1'b0;
                    state_d      = StResp;
                end else if (cnt_expired) begin
                    rsp_result_d = '0;
                    rsp_error_d  = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    // Handshake outputs depend on state only, never on the other side's signals.
    assign bus.req_ready  = (state_q == StIdle);
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_error  = rsp_error_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_start  = (state_q == StIssue) && is_multicycle(alu_opcode_q);
    assign busy           = (state_q != StIdle);
endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler (WIDTH=32, TIMEOUT=8).
module tb_alu_scheduler;
    import alu_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int checks = 0;
    int failures = 0;

    alu_scheduler_if #(.WIDTH(W)) bus ();

    alu_scheduler #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Behavioural functional units: result follows the held opcode/operands.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_opcode)
            OP_ADD:   bus.alu_result = bus.alu_a + bus.alu_b;
            OP_SUB:   bus.alu_result = bus.alu_a - bus.alu_b;
            OP_MUL:   bus.alu_result = bus.alu_a * bus.alu_b;
            OP_SHIFT: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            OP_AND:   bus.alu_result = bus.alu_a & bus.alu_b;
            OP_OR:    bus.alu_result = bus.alu_a | bus.alu_b;
            OP_XOR:   bus.alu_result = bus.alu_a ^ bus.alu_b;
            OP_DIV:   bus.alu_result = (bus.alu_b != '0) ? bus.alu_a / bus.alu_b : '0;
            default:  bus.alu_result = '0;
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          done_n;     // WAIT cycle index for alu_done, -1 = never
        int          exp_lat;    // cycles from accept to rsp_valid
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_starts;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int starts;
        int lat;
        logic [31:0] res;
        logic err;
        string tag;
        tag = $sformatf("vec%0d", idx);
        starts = 0;
        lat = -1;
        res = '0;
        err = 1'b0;
        check({tag, "_ready_before"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_opcode = v.op;
        bus.req_a      = v.a;
        bus.req_b      = v.b;
        bus.rsp_ready  = 1'b1;
        bus.alu_done   = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        cyc = 1;
        while (cyc <= 40) begin
            bus.alu_done = (v.done_n >= 0) && (cyc == 2 + v.done_n);
            if (bus.alu_start) starts++;
            if (bus.rsp_valid) begin
                lat = cyc;
                res = bus.rsp_result;
                err = bus.rsp_error;
                break;
            end
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_result"}, res, v.exp_res);
        check({tag, "_error"}, 32'(err), 32'(v.exp_err));
        check({tag, "_starts"}, 32'(starts), 32'(v.exp_starts));
        tick();
        bus.alu_done = 1'b0;
        check({tag, "_idle_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int starts;
        int seen;

        vecs[0]  = '{OP_ADD,   32'd5,          32'd7,          -1, 2,  32'd12,         1'b0, 0};
        vecs[1]  = '{OP_SUB,   32'd10,         32'd3,          -1, 2,  32'd7,          1'b0, 0};
        vecs[2]  = '{OP_AND,   32'h0000_ff0f,  32'h0000_0f0f,  -1, 2,  32'h0000_0f0f,  1'b0, 0};
        vecs[3]  = '{OP_OR,    32'h0000_00f0,  32'h0000_000f,  -1, 2,  32'h0000_00ff,  1'b0, 0};
        vecs[4]  = '{OP_XOR,   32'h0000_00ff,  32'h0000_000f,  -1, 2,  32'h0000_00f0,  1'b0, 0};
        vecs[5]  = '{OP_SHIFT, 32'd1,          32'd4,          -1, 2,  32'd16,         1'b0, 0};
        vecs[6]  = '{OP_MUL,   32'd3,          32'd4,           4, 7,  32'd12,         1'b0, 1};
        vecs[7]  = '{OP_MUL,   32'd3,          32'd4,           0, 3,  32'd12,         1'b0, 1};
        vecs[8]  = '{OP_DIV,   32'd9,          32'd0,          -1, 1,  32'hffff_ffff,  1'b1, 0};
        vecs[9]  = '{OP_DIV,   32'd9,          32'd3,          -1, 10, 32'd0,          1'b1, 1};
        vecs[10] = '{OP_DIV,   32'd9,          32'd3,           7, 10, 32'd3,          1'b0, 1};
        vecs[11] = '{OP_SUB,   32'd0,          32'd1,          -1, 2,  32'hffff_ffff,  1'b0, 0};

        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b0;
        bus.alu_done   = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_busy",      32'(busy),          32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_opcode",    32'(bus.alu_opcode), 32'd0);
        check("rst_alu_a",     bus.alu_a,          32'd0);
        check("rst_result",    bus.rsp_result,     32'd0);
        check("rst_error",     32'(bus.rsp_error), 32'd0);
        check("rst_start",     32'(bus.alu_start), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: response stalled while a second request waits.
        bus.req_valid  = 1'b1;
        bus.req_opcode = OP_ADD;
        bus.req_a      = 32'd5;
        bus.req_b      = 32'd7;
        bus.rsp_ready  = 1'b0;
        tick();
        bus.req_opcode = OP_SUB;
        bus.req_a      = 32'd10;
        bus.req_b      = 32'd3;
        tick();
        check("bp_first_valid", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_valid_c%0d", i),  32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp_result_c%0d", i), bus.rsp_result,     32'd12);
            check($sformatf("bp_ready_c%0d", i),  32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_ready_after_hs", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check("bp_second_busy",   32'(busy),           32'd1);
        check("bp_second_opcode", 32'(bus.alu_opcode), 32'(OP_SUB));
        check("bp_second_a",      bus.alu_a,           32'd10);
        tick();
        check("bp_second_valid",  32'(bus.rsp_valid),  32'd1);
        check("bp_second_result", bus.rsp_result,      32'd7);
        tick();

        // Reset while waiting on a multi-cycle unit.
        bus.req_valid  = 1'b1;
        bus.req_opcode = OP_MUL;
        bus.req_a      = 32'd3;
        bus.req_b      = 32'd4;
        bus.alu_done   = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy",      32'(busy),           32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready),  32'd1);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid),  32'd0);
        check("mid_rst_opcode",    32'(bus.alu_opcode), 32'd0);
        starts = 0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.alu_start) starts++;
            if (bus.rsp_valid) seen++;
            if (i == 5) bus.alu_done = 1'b1;
            tick();
        end
        bus.alu_done = 1'b0;
        check("mid_rst_no_start", 32'(starts), 32'd0);
        check("mid_rst_no_rsp",   32'(seen),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
